lstm_seq_ctrl: RTL and testbench

Sequence controller that sits directly upstream of the lstm block. It accepts a stream of input vectors x(t) for one sequence and presents them to the cell one timestep at a time. It drives the cell's sel so that h(t-1)=0 on the first step. It captures the cell's h(t) and c(t) for every step into a local history buffer, which backpropagation reads back afterwards.

---
 rtl/lstm_seq_ctrl.sv | 158 +++++++++++++++
 tb/tb_lstm_seq_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lstm_seq_ctrl.sv
// lstm_seq_ctrl: sequence controller upstream of the lstm cell.
// Steps x(t) into the cell one timestep at a time and keeps an h/c history buffer.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   i_start, i_len  start a sequence of i_len steps (clamped to TMAX), IDLE only
//   i_x_valid, i_x  upstream x vector; o_x_ready accepts it
//   o_x, o_sel      registered x and h(t-1) select to the cell (sel=0 zeroes h)
//   i_h, i_c        cell outputs, captured into history once per step
//   o_busy, o_done  not-idle flag, one-cycle end-of-sequence pulse
//   o_step          current timestep index
//   i_rd_addr       history read address; o_rd_h/o_rd_c valid one cycle later
module lstm_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int NUM   = 3,
    parameter int TMAX  = 8,
    parameter int LAT   = 1,
    parameter int AW    = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    input  logic [AW:0]               i_len,
    input  logic                      i_x_valid,
    input  logic [(NUM-1)*WIDTH-1:0]  i_x,
    output logic                      o_x_ready,
    output logic [(NUM-1)*WIDTH-1:0]  o_x,
    output logic                      o_sel,
    input  logic [WIDTH-1:0]          i_h,
    input  logic [WIDTH-1:0]          i_c,
    output logic                      o_busy,
    output logic                      o_done,
    output logic [AW-1:0]             o_step,
    input  logic [AW-1:0]             i_rd_addr,
    output logic [WIDTH-1:0]          o_rd_h,
    output logic [WIDTH-1:0]          o_rd_c
);

    localparam int XW = (NUM-1)*WIDTH;
    localparam int CW = $clog2(LAT+1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_e;

    state_e            state_q;
    logic [AW:0]       len_q;
    logic [AW:0]       len_d;
    logic [AW-1:0]     step_q;
    logic [CW-1:0]     wcnt_q;
    logic [XW-1:0]     x_q;
    logic              sel_q;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  rd_h_q;
    logic [WIDTH-1:0]  rd_c_q;
    logic              cap;
    logic              last_step;

    logic [WIDTH-1:0]  hist_h [TMAX];
    logic [WIDTH-1:0]  hist_c [TMAX];

    always_comb begin
        len_d = i_len;
        if (i_len > (AW+1)'(TMAX)) begin
            len_d = (AW+1)'(TMAX);
        end
    end

    // Capture happens on the last WAIT cycle, when the cell output has settled.
    assign cap       = (state_q == S_WAIT) && (wcnt_q == CW'(1));
    assign last_step = ({1'b0, step_q} == (len_q - (AW+1)'(1)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            step_q  <= '0;
            wcnt_q  <= '0;
            x_q     <= '0;
            sel_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_h_q  <= '0;
            rd_c_q  <= '0;
        end else begin
            done_q <= 1'b0;
            rd_h_q <= hist_h[i_rd_addr];
            rd_c_q <= hist_c[i_rd_addr];
            unique case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        len_q  <= len_d;
                        step_q <= '0;
                        busy_q <= 1'b1;
                        if (len_d == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            sel_q   <= 1'b0;
                        end else begin
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (i_x_valid) begin
                        x_q     <= i_x;
                        // First step of every sequence forces h(t-1)=0.
                        sel_q   <= (step_q != '0);
                        wcnt_q  <= CW'(LAT);
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q - CW'(1);
                    if (cap) begin
                        if (last_step) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                            sel_q   <= 1'b0;
                        end else begin
                            step_q  <= step_q + AW'(1);
                            state_q <= S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // History is intentionally not reset; readers only trust completed sequences.
    always_ff @(posedge clk) begin
        if (cap) begin
            hist_h[step_q] <= i_h;
            hist_c[step_q] <= i_c;
        end
    end

    assign o_x_ready = (state_q == S_LOAD);
    assign o_x       = x_q;
    assign o_sel     = sel_q;
    assign o_busy    = busy_q;
    assign o_done    = done_q;
    assign o_step    = step_q;
    assign o_rd_h    = rd_h_q;
    assign o_rd_c    = rd_c_q;

endmodule

// File: tb/tb_lstm_seq_ctrl.sv
// tb_lstm_seq_ctrl: directed bench for lstm_seq_ctrl.
// Two instances: LAT=1 (u1) and LAT=2 (u2) on shared stimulus.
module tb_lstm_seq_ctrl;

    localparam int W  = 32;
    localparam int N  = 3;
    localparam int AW = 3;
    localparam int XW = (N-1)*W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start;
    logic [AW:0]   len;
    logic          xv;
    logic [XW-1:0] x;
    logic [W-1:0]  h;
    logic [W-1:0]  c;
    logic [AW-1:0] ra;

    logic          rdy1, sel1, busy1, done1;
    logic [XW-1:0] ox1;
    logic [AW-1:0] step1;
    logic [W-1:0]  rdh1, rdc1;

    logic          rdy2, sel2, busy2, done2;
    logic [XW-1:0] ox2;
    logic [AW-1:0] step2;
    logic [W-1:0]  rdh2, rdc2;

    int n_chk  = 0;
    int n_pass = 0;
    int np;
    int dc;

    always #5 clk = ~clk;

    lstm_seq_ctrl #(.WIDTH(W), .NUM(N), .TMAX(8), .LAT(1), .AW(AW)) u1 (
        .clk(clk), .rst(rst), .i_start(start), .i_len(len),
        .i_x_valid(xv), .i_x(x), .o_x_ready(rdy1), .o_x(ox1),
        .o_sel(sel1), .i_h(h), .i_c(c), .o_busy(busy1),
        .o_done(done1), .o_step(step1), .i_rd_addr(ra),
        .o_rd_h(rdh1), .o_rd_c(rdc1)
    );

    lstm_seq_ctrl #(.WIDTH(W), .NUM(N), .TMAX(8), .LAT(2), .AW(AW)) u2 (
        .clk(clk), .rst(rst), .i_start(start), .i_len(len),
        .i_x_valid(xv), .i_x(x), .o_x_ready(rdy2), .o_x(ox2),
        .o_sel(sel2), .i_h(h), .i_c(c), .o_busy(busy2),
        .o_done(done2), .o_step(step2), .i_rd_addr(ra),
        .o_rd_h(rdh2), .o_rd_c(rdc2)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
    endtask

    task automatic kick(input int l);
        start = 1'b1;
        len   = (AW+1)'(l);
        tick();
        start = 1'b0;
    endtask

    // Inputs for edge k+1: x steps every 2 cycles, h only valid on capture edges.
    task automatic pat1(input int k);
        x = {32'(k/2+257), 32'(k/2+1)};
        h = (k%2 == 1) ? 32'(16*(k/2+1)) : 32'hEE;
        c = h + 32'd1;
    endtask

    initial begin
        start = 1'b0; len = '0; xv = 1'b1;
        x = '0; h = '0; c = '0; ra = '0;

        // Reset state, checked while reset is held.
        #2 rst = 1'b0;
        #1;
        check("rst_x",    64'(ox1),   0);
        check("rst_sel",  64'(sel1),  0);
        check("rst_rdy",  64'(rdy1),  0);
        check("rst_busy", 64'(busy1), 0);
        check("rst_done", 64'(done1), 0);
        check("rst_step", 64'(step1), 0);
        check("rst_rdh",  64'(rdh1),  0);
        check("rst_rdc",  64'(rdc1),  0);
        repeat (2) tick();
        rst = 1'b1;

        // 1: LAT=1, len=3, valid held high.
        pat1(0);
        kick(3);
        check("t1_busy", 64'(busy1), 1);
        check("t1_rdy",  64'(rdy1),  1);
        np = 0; dc = 0;
        for (int k = 0; k < 12; k++) begin
            pat1(k);
            tick();
            if (done1) begin np++; dc = k+2; end
            if (k+1 == 1) begin
                check("t1_x0", 64'(ox1), {32'd257, 32'd1});
                check("t1_sel0", 64'(sel1), 0);
            end
            if (k+1 == 3) begin
                check("t1_x1", 64'(ox1), {32'd258, 32'd2});
                check("t1_sel1", 64'(sel1), 1);
            end
            if (k+1 == 5) begin
                check("t1_x2", 64'(ox1), {32'd259, 32'd3});
                check("t1_sel2", 64'(sel1), 1);
            end
            if (k+1 == 6) begin
                check("t1_dsel", 64'(sel1), 0);
                check("t1_dstep", 64'(step1), 2);
            end
        end
        check("t1_npulse", 64'(np), 1);
        check("t1_dcyc", 64'(dc), 7);
        check("t1_xhold", 64'(ox1), {32'd259, 32'd3});
        check("t1_idle", 64'(busy1), 0);
        check("t1_stephold", 64'(step1), 2);
        for (int a = 0; a < 3; a++) begin
            ra = AW'(a);
            tick();
            check("t1_rdh", 64'(rdh1), 64'(16*(a+1)));
            check("t1_rdc", 64'(rdc1), 64'(16*(a+1)+1));
        end

        // 2: LAT=2, len=2, 4-cycle stall in LOAD of step 1.
        do_reset();
        xv = 1'b1;
        x = 64'd768;
        kick(2);
        np = 0; dc = 0;
        for (int k = 0; k < 16; k++) begin
            xv = !(k >= 3 && k <= 6);
            x  = 64'(768 + k + 1);
            h  = 32'(512 + k + 1);
            c  = h ^ 32'hFFFF0000;
            tick();
            if (done2) begin np++; dc = k+2; end
            if (k+1 == 1) begin
                check("t2_x0", 64'(ox2), 769);
                check("t2_sel0", 64'(sel2), 0);
            end
            if (k+1 >= 4 && k+1 <= 7) begin
                check("t2_rdy", 64'(rdy2), 1);
                check("t2_xhold", 64'(ox2), 769);
                check("t2_selhold", 64'(sel2), 0);
            end
            if (k+1 == 8) begin
                check("t2_x1", 64'(ox2), 776);
                check("t2_sel1", 64'(sel2), 1);
            end
        end
        xv = 1'b1;
        check("t2_npulse", 64'(np), 1);
        check("t2_dcyc", 64'(dc), 11);
        ra = 0;
        tick();
        check("t2_rdh0", 64'(rdh2), 515);
        check("t2_rdc0", 64'(rdc2), 64'(32'd515 ^ 32'hFFFF0000));
        ra = 1;
        tick();
        check("t2_rdh1", 64'(rdh2), 522);
        check("t2_rdc1", 64'(rdc2), 64'(32'd522 ^ 32'hFFFF0000));

        // 3a: len=0 finishes immediately.
        do_reset();
        kick(0);
        check("t3_done", 64'(done1), 1);
        check("t3_rdy", 64'(rdy1), 0);
        tick();
        check("t3_done_off", 64'(done1), 0);
        check("t3_idle", 64'(busy1), 0);

        // 3b: len=12 clamps to 8 steps.
        do_reset();
        kick(12);
        np = 0; dc = 0;
        for (int k = 0; k < 24; k++) begin
            h = (k%2 == 1) ? 32'(1024 + k) : 32'hBAD;
            c = h + 32'd1;
            tick();
            if (done1) begin np++; dc = k+2; end
        end
        check("t3_npulse", 64'(np), 1);
        check("t3_dcyc", 64'(dc), 17);
        check("t3_step", 64'(step1), 7);
        for (int a = 0; a < 8; a++) begin
            ra = AW'(a);
            tick();
            check("t3_rdh", 64'(rdh1), 64'(1024 + 2*a + 1));
        end

        // 4: start pulsed during WAIT of step 1 is ignored.
        do_reset();
        pat1(0);
        kick(3);
        np = 0; dc = 0;
        for (int k = 0; k < 12; k++) begin
            pat1(k);
            if (k == 3) begin start = 1'b1; len = 1; end
            if (k == 4) start = 1'b0;
            tick();
            if (done1) begin np++; dc = k+2; end
        end
        check("t4_npulse", 64'(np), 1);
        check("t4_dcyc", 64'(dc), 7);
        check("t4_step", 64'(step1), 2);

        // 5: async reset mid-WAIT of step 1.
        do_reset();
        pat1(0);
        kick(3);
        for (int k = 0; k < 3; k++) begin
            pat1(k);
            tick();
        end
        check("t5_sel_pre", 64'(sel1), 1);
        #3 rst = 1'b0;
        #1;
        check("t5_busy", 64'(busy1), 0);
        check("t5_sel", 64'(sel1), 0);
        check("t5_x", 64'(ox1), 0);
        check("t5_step", 64'(step1), 0);
        check("t5_rdy", 64'(rdy1), 0);
        np = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (done1) np++;
        end
        check("t5_nodone", 64'(np), 0);
        rst = 1'b1;
        pat1(0);
        kick(1);
        pat1(0);
        tick();
        check("t5_sel_new", 64'(sel1), 0);
        np = 0; dc = 0;
        for (int e = 2; e < 6; e++) begin
            pat1(e-1);
            tick();
            if (done1) begin np++; dc = e+1; end
        end
        check("t5_npulse", 64'(np), 1);
        check("t5_dcyc", 64'(dc), 3);

        // 6: read/write collision on address 1 (old value 0x20 from run 4).
        do_reset();
        ra = 1;
        x = 64'd5;
        kick(2);
        for (int k = 0; k < 8; k++) begin
            h = (k%2 == 1) ? 32'(1536 + k) : 32'h0;
            c = h + 32'd1;
            tick();
            if (k+1 == 4) begin
                check("t6_old_h", 64'(rdh1), 32);
                check("t6_old_c", 64'(rdc1), 33);
            end
            if (k+1 == 5) begin
                check("t6_new_h", 64'(rdh1), 1539);
                check("t6_new_c", 64'(rdc1), 1540);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
